// File: rtl/demux_burst_scheduler.sv
// Burst scheduler that sits in front of the 1:N demux fabric. It grants enabled, ready
// channels round-robin, then steers up to BURST beats through a one-deep output hold stage.
//
//   state   | meaning
//   S_IDLE  | arbitrate: pick the next eligible channel after last_ch
//   S_BURST | stream beats to sel until BURST accepts or ch_en[sel] drops
module demux_burst_scheduler #(
    parameter int NCH   = 6,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   out_ready,
    output logic [W-1:0]     out_data,
    output logic [NCH-1:0]   out_valid,
    output logic [2:0]       sel,
    output logic             busy,
    output logic [3:0]       beat_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]   r_state;
    logic [2:0]   r_sel;
    logic [2:0]   r_last_ch;
    logic [3:0]   r_beat_cnt;
    logic         r_hold_v;
    logic [2:0]   r_hold_ch;
    logic [W-1:0] r_hold_data;

    logic [7:0]   w_en8;
    logic [7:0]   w_rdy8;
    logic [7:0]   w_elig;
    logic         w_grant_v;
    logic [2:0]   w_grant_ch;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_last_beat;
    logic         w_drain;

    // Widen the masks to 8 bits so a 3-bit index can never select past the vector.
    always_comb begin
        w_en8            = '0;
        w_rdy8           = '0;
        w_en8[NCH-1:0]   = ch_en;
        w_rdy8[NCH-1:0]  = out_ready;
        w_elig           = w_en8 & w_rdy8;
    end

    always_comb begin
        int c_idx;
        w_grant_v  = 1'b0;
        w_grant_ch = '0;
        c_idx      = 0;
        for (int k = 1; k <= NCH; k++) begin
            c_idx = int'(r_last_ch) + k;
            if (c_idx >= NCH) c_idx = c_idx - NCH;
            if (!w_grant_v && w_elig[c_idx[2:0]]) begin
                w_grant_v  = 1'b1;
                w_grant_ch = c_idx[2:0];
            end
        end
    end

    // A pending beat for another channel must leave the hold stage before this burst may load it.
    assign w_in_ready  = (r_state == S_BURST) & w_en8[r_sel] &
                         (~r_hold_v | ((r_hold_ch == r_sel) & w_rdy8[r_sel]));
    assign w_accept    = in_valid & w_in_ready;
    assign w_last_beat = (r_beat_cnt == 4'(BURST - 1));
    assign w_drain     = r_hold_v & w_rdy8[r_hold_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_last_ch  <= 3'(NCH - 1);
            r_beat_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (in_valid && w_grant_v) begin
                r_state    <= S_BURST;
                r_sel      <= w_grant_ch;
                r_last_ch  <= w_grant_ch;
                r_beat_cnt <= '0;
            end
        end else begin
            if (!w_en8[r_sel]) begin
                r_state <= S_IDLE;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
                if (w_last_beat) r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v    <= 1'b0;
            r_hold_ch   <= '0;
            r_hold_data <= '0;
        end else if (w_accept) begin
            r_hold_v    <= 1'b1;
            r_hold_ch   <= r_sel;
            r_hold_data <= in_data;
        end else if (w_drain) begin
            r_hold_v    <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_hold_data;
    assign out_valid = r_hold_v ? ({{(NCH-1){1'b0}}, 1'b1} << r_hold_ch) : '0;
    assign sel       = r_sel;
    assign busy      = (r_state == S_BURST);
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Self-checking bench for demux_burst_scheduler: a transaction-level model of grants,
// burst counts and the pending beat, plus per-channel FIFOs that verify delivery order.
module tb_demux_burst_scheduler;
    localparam int NCH   = 6;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] out_ready;
    logic [W-1:0]   out_data;
    logic [NCH-1:0] out_valid;
    logic [2:0]     sel;
    logic           busy;
    logic [3:0]     beat_cnt;

    always #5 clk = ~clk;

    demux_burst_scheduler #(.NCH(NCH), .W(W), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ch_en(ch_en), .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .sel(sel), .busy(busy), .beat_cnt(beat_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: burst in progress, granted channel, beats taken, one pending beat.
    bit         m_init = 0;
    bit         m_busy;
    int         m_sel, m_last, m_cnt;
    bit         m_pv;
    int         m_pch;
    logic [7:0] m_pdata;
    logic [7:0] exp_q [NCH][$];
    logic [7:0] got_q [NCH][$];
    int         grant_log [$];
    bit         last_acc;
    int         seq;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_busy && ch_en[m_sel] && (!m_pv || (m_pch == m_sel && out_ready[m_sel]));
    endfunction

    task automatic model_reset();
        m_init = 1; m_busy = 0; m_sel = 0; m_last = NCH - 1; m_cnt = 0;
        m_pv = 0; m_pch = 0; m_pdata = '0;
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            got_q[c].delete();
        end
        grant_log.delete();
    endtask

    task automatic step();
        logic [NCH-1:0] a_ov;
        logic [7:0]     a_od;
        bit             acc;
        bit             found;
        #2;
        if (m_init) begin
            check("in_ready",  {31'd0, in_ready}, {31'd0, m_ready()});
            check("out_valid", {26'd0, out_valid}, m_pv ? (32'd1 << m_pch) : 32'd0);
            check("out_data",  {24'd0, out_data}, {24'd0, m_pdata});
            check("busy",      {31'd0, busy}, {31'd0, m_busy});
            check("sel",       {29'd0, sel}, m_sel);
            check("beat_cnt",  {28'd0, beat_cnt}, m_cnt);
        end
        a_ov = out_valid;
        a_od = out_data;
        acc  = m_ready() && in_valid;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_init) begin
            for (int c = 0; c < NCH; c++) begin
                if (a_ov[c] && out_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL sb_extra ch%0d: got beat %0h expected none", c, a_od);
                    end else begin
                        check("sb_data", {24'd0, a_od}, {24'd0, exp_q[c].pop_front()});
                        got_q[c].push_back(a_od);
                    end
                end
            end
            if (acc) begin
                exp_q[m_sel].push_back(in_data);
                m_pv = 1; m_pch = m_sel; m_pdata = in_data;
            end else if (m_pv && out_ready[m_pch]) begin
                m_pv = 0;
            end
            if (m_busy) begin
                if (!ch_en[m_sel]) m_busy = 0;
                else if (acc) begin
                    m_cnt++;
                    if (m_cnt == BURST) m_busy = 0;
                end
            end else if (in_valid) begin
                found = 0;
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (!found && ch_en[c] && out_ready[c]) begin
                        found = 1; m_busy = 1; m_sel = c; m_last = c; m_cnt = 0;
                        grant_log.push_back(c);
                    end
                end
            end
        end
        last_acc = acc && !rst;
        #1;
    endtask

    task automatic run_seq(input int n);
        repeat (n) begin
            in_data = seq[7:0];
            step();
            if (last_acc) seq++;
        end
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0;
        step();
        rst = 0; seq = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; ch_en = '1; out_ready = '1; seq = 0;
        do_reset();
        check("rst_busy",      {31'd0, busy}, 0);
        check("rst_in_ready",  {31'd0, in_ready}, 0);
        check("rst_sel",       {29'd0, sel}, 0);
        check("rst_out_valid", {26'd0, out_valid}, 0);
        check("rst_out_data",  {24'd0, out_data}, 0);
        check("rst_beat_cnt",  {28'd0, beat_cnt}, 0);

        // Continuous traffic, all channels: 4-beat bursts rotate ch0..ch5.
        in_valid = 1;
        run_seq(40);
        check("t1_ch0_n", got_q[0].size(), 8);
        if (got_q[0].size() >= 5) check("t1_ch0_b4", {24'd0, got_q[0][4]}, 24);
        if (got_q[5].size() >= 1) check("t1_ch5_b0", {24'd0, got_q[5][0]}, 20);
        if (got_q[1].size() >= 4) check("t1_ch1_b3", {24'd0, got_q[1][3]}, 7);

        // Only ch2 and ch5 enabled.
        do_reset();
        ch_en = 6'b100100; in_valid = 1;
        run_seq(20);
        check("t2_ngrants", grant_log.size(), 4);
        if (grant_log.size() >= 3) begin
            check("t2_g0", grant_log[0], 2);
            check("t2_g1", grant_log[1], 5);
            check("t2_g2", grant_log[2], 2);
        end
        check("t2_quiet", got_q[0].size() + got_q[1].size() + got_q[3].size() + got_q[4].size(), 0);

        // Stall ch1 for 5 cycles after its first beat.
        do_reset();
        ch_en = '1; out_ready = 6'b111110; in_valid = 1;
        for (int i = 0; i < 10 && seq == 0; i++) run_seq(1);
        check("t3_first_acc", seq, 1);
        out_ready = 6'b111100;
        repeat (5) begin
            in_data = seq[7:0];
            step();
            check("t3_stall_ov",  {26'd0, out_valid}, 32'h02);
            check("t3_stall_od",  {24'd0, out_data}, 0);
            check("t3_stall_rdy", {31'd0, in_ready}, 0);
        end
        out_ready = 6'b111110;
        run_seq(12);
        check("t3_ch1_n", got_q[1].size(), 4);
        if (got_q[1].size() >= 4) check("t3_ch1_b3", {24'd0, got_q[1][3]}, 3);

        // Truncate a ch3 burst after 2 beats.
        do_reset();
        ch_en = 6'b011000; out_ready = '1; in_valid = 1;
        for (int i = 0; i < 10 && !(m_busy && m_cnt == 2); i++) run_seq(1);
        ch_en = 6'b010000;
        run_seq(1);
        check("t4_cnt",  {28'd0, beat_cnt}, 2);
        check("t4_busy", {31'd0, busy}, 0);
        run_seq(6);
        check("t4_ngrants", grant_log.size() >= 2, 1);
        if (grant_log.size() >= 2) check("t4_next", grant_log[1], 4);
        check("t4_ch3_n", got_q[3].size(), 2);
        if (got_q[3].size() >= 2) check("t4_ch3_b1", {24'd0, got_q[3][1]}, 1);

        // Reset during a ch1 burst with a beat pending.
        do_reset();
        ch_en = '1; out_ready = '1; in_valid = 1;
        for (int i = 0; i < 20 && !(m_busy && m_sel == 1 && m_pv); i++) run_seq(1);
        check("t5_pending", {31'd0, out_valid[1]}, 1);
        rst = 1;
        step();
        rst = 0;
        check("t5_out_valid", {26'd0, out_valid}, 0);
        check("t5_in_ready",  {31'd0, in_ready}, 0);
        check("t5_busy",      {31'd0, busy}, 0);
        check("t5_sel",       {29'd0, sel}, 0);
        run_seq(1);
        check("t5_ngrants", grant_log.size(), 1);
        if (grant_log.size() >= 1) check("t5_grant", grant_log[0], 0);

        // in_valid pulses once every 3 cycles.
        do_reset();
        ch_en = '1; out_ready = '1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c % 3 == 0);
            run_seq(1);
        end
        check("t6_ngrants", grant_log.size(), 2);
        check("t6_ch0_n", got_q[0].size(), 4);

        // Random traffic, enables, backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NCH; b++) begin
                ch_en[b]     = ($urandom_range(7) != 0);
                out_ready[b] = ($urandom_range(3) != 0);
            end
            in_valid = ($urandom_range(3) != 0);
            rst      = ($urandom_range(399) == 0);
            in_data  = 8'($urandom);
            step();
        end
        rst = 0; in_valid = 0; out_ready = '1;
        repeat (4) step();
        for (int c = 0; c < NCH; c++) check("drain_empty", exp_q[c].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/demux_burst_scheduler.md
# demux_burst_scheduler

Sequencing controller for the 1:6 demultiplexer datapath. It takes one valid/ready input stream and distributes it in bursts of BURST beats to six output channels. Channels are granted round-robin among those that are enabled and ready. The block sits in front of the demux fabric: it generates the channel select, drives a registered data/valid stage toward the selected consumer, and enforces per-channel backpressure.

## Interface
Parameters:
- NCH, 6, number of output channels (2..8)
- W, 8, data width
- BURST, 4, beats per grant (1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  W  input beat
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- ch_en  in  NCH  per-channel enable mask
- out_ready  in  NCH  per-channel consumer ready
- out_data  out  W  registered beat, shared by all channels
- out_valid  out  NCH  one-hot; bit i means out_data is for channel i
- sel  out  3  currently granted channel index
- busy  out  1  state is BURST
- beat_cnt  out  4  beats accepted in current burst

## Operation
- Eligible channel i: ch_en[i] & out_ready[i]. Indices >= NCH never exist.
- FSM with two states.
- IDLE:
  - in_ready=0.
  - If in_valid and any channel is eligible, grant the first eligible channel scanning last_ch+1, last_ch+2, … with wrap NCH-1→0.
  - On grant: sel<=granted index, last_ch<=granted index, beat_cnt<=0, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - in_ready = ch_en[sel] & (~hold_v | (hold_ch==sel & out_ready[sel])).
  - Accept = in_valid & in_ready. On accept: hold register<=in_data, hold_ch<=sel, hold_v<=1, beat_cnt<=beat_cnt+1.
  - When the accept makes beat_cnt reach BURST, go to IDLE.
  - If ch_en[sel] is low, go to IDLE without accepting. The burst is truncated, and the beats accepted so far stand.
  - If in_valid is low, stay in BURST; a burst waits for input indefinitely.
- Output stage:
  - out_data=hold data. out_valid = hold_v ? (1<<hold_ch) : 0.
  - hold_v clears on out_ready[hold_ch] unless a new accept occurs in the same cycle.
  - The hold register drains independently of the FSM: a beat from the previous burst may still be pending while IDLE arbitrates.
  - In BURST, a new accept is blocked until the pending beat for a different channel drains.
- out_data holds its last value when out_valid=0.
- No beat is dropped or duplicated. Beat order is preserved per channel.
- Reset, including mid-burst or with a beat pending:
  - state=IDLE, hold_v=0, out_valid=0, out_data=0, in_ready=0, sel=0, busy=0, beat_cnt=0, last_ch=NCH-1 (so channel 0 has first priority).
  - A pending beat is discarded.

## Timing
- Arbitration takes 1 cycle: the grant decision is in an IDLE cycle, and in_ready can assert in the next cycle.
- Latency is 1 cycle: a beat accepted at edge t is on out_data/out_valid after edge t.
- Throughput within a burst is 1 beat/cycle while out_ready[sel]=1.
- Burst-to-burst gap is exactly 1 idle cycle, given that in_valid and an eligible channel are present.
- ch_en and out_ready are sampled combinationally for eligibility and for in_ready. No registered lookahead.
- Simultaneous events:
  - Drain of the previous beat and accept of a new beat in the same cycle: hold_v stays 1 with the new data.
  - ch_en[sel] falling while in_valid=1: no accept; IDLE next cycle.
  - Final beat of a burst accepted while out_ready is low: the FSM goes to IDLE, and the beat is held until drained.
- beat_cnt is 4 bits and never exceeds BURST; it does not wrap.

## Test plan
- Reset then continuous in_valid, all ch_en=1, all out_ready=1, BURST=4, data 0,1,2,… → beats 0-3 on ch0, 4-7 on ch1, …, 20-23 on ch5, 24-27 on ch0. One dead cycle between bursts, each out_valid one cycle after its accept.
- ch_en=6'b100100, all ready → grants alternate ch2, ch5, ch2. Channels 0, 1, 3, 4 never see out_valid.
- Grant on ch1, then out_ready[1]=0 for 5 cycles after the first beat → in_ready=0 and out_valid=6'b000010 held stable with unchanged data for 5 cycles. Transfer resumes afterwards with no loss.
- ch_en[3] cleared after 2 beats of a ch3 burst → FSM returns to IDLE, beat_cnt=2 observed. Next grant is ch4, and the truncated burst's last beat still delivers on ch3.
- Assert rst mid-burst with hold_v=1 → next cycle: out_valid=0, in_ready=0, busy=0, sel=0. The first post-reset grant is ch0.
- in_valid pulses 1 cycle every 3 cycles during a burst → beat_cnt steps 1..4 only on accepts. The burst ends after the 4th accept, and no grant occurs while in_valid=0 in IDLE.
